// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch unit that issues single outstanding reads to instruction memory and
// feeds a 2-entry {word, address} buffer towards the decode stage.
//
// Ports
//   CLK          single clock, rising-edge
//   RESET        synchronous active-high reset
//   MEM_ADDR     fetch address (FPC, or the stale address while discarding)
//   MEM_RD       read request, high in REQ and DISCARD
//   MEM_ACK      memory returns valid data on MEM_DIN this cycle
//   MEM_DIN      instruction word from memory
//   INSTR        word at buffer head, zero when empty
//   INSTR_VALID  buffer non-empty
//   INSTR_READY  decode accepts the head this cycle
//   PC_OUT       address of the head word, zero when empty
//   JUMP         redirect fetch to JUMP_ADDR and flush everything in flight
//   JUMP_ADDR    jump target
//   SKIP         drop the instruction following the one popped this cycle
//   HALT         suppress new memory requests
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic [15:0] MEM_ADDR,
   output logic        MEM_RD,
   input  logic        MEM_ACK,
   input  logic [15:0] MEM_DIN,
   output logic [15:0] INSTR,
   output logic        INSTR_VALID,
   input  logic        INSTR_READY,
   output logic [15:0] PC_OUT,
   input  logic        JUMP,
   input  logic [15:0] JUMP_ADDR,
   input  logic        SKIP,
   input  logic        HALT
);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] fpc;
   logic [15:0] old_addr;
   logic [15:0] word0, addr0, word1, addr1;
   logic [1:0]  count;
   logic        pend_skip;

   logic pop;
   logic ack_req;
   logic skip_pop;
   logic wr;

   assign pop      = (count != 2'd0) & INSTR_READY;
   assign ack_req  = (state == REQ) & MEM_ACK;
   assign skip_pop = pop & SKIP;
   // A word arriving in the same cycle as a skip-pop at count 1 is exactly the
   // instruction to be skipped, so it is dropped here instead of arming
   // pend_skip. At count 2 no request can be outstanding.
   assign wr       = ack_req & ~JUMP & ~pend_skip & ~skip_pop;

   // state register
   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if ((count != 2'd2) && !HALT && !JUMP) state_nxt = REQ;
         end
         REQ: begin
            if (JUMP)         state_nxt = MEM_ACK ? IDLE : DISCARD;
            else if (MEM_ACK) state_nxt = IDLE;
         end
         DISCARD: begin
            if (MEM_ACK) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // outputs: while discarding, the bus keeps the address of the abandoned
   // request even though FPC already holds the jump target
   always_comb begin
      MEM_RD   = (state == REQ) || (state == DISCARD);
      MEM_ADDR = (state == DISCARD) ? old_addr : fpc;
   end

   assign INSTR_VALID = (count != 2'd0);
   assign INSTR       = INSTR_VALID ? word0 : 16'h0000;
   assign PC_OUT      = INSTR_VALID ? addr0 : 16'h0000;

   // control state: fetch pointer, occupancy, pending skip
   always_ff @(posedge CLK) begin
      if (RESET) begin
         fpc       <= RESET_VECTOR;
         count     <= 2'd0;
         pend_skip <= 1'b0;
      end else if (JUMP) begin
         fpc       <= JUMP_ADDR;
         count     <= 2'd0;
         pend_skip <= 1'b0;
      end else begin
         if (ack_req) fpc <= fpc + 16'd1;
         if (ack_req && pend_skip)
            pend_skip <= 1'b0;
         else if (skip_pop && (count == 2'd1) && !ack_req)
            pend_skip <= 1'b1;
         if (skip_pop)
            count <= 2'd0;
         else if (pop && !wr)
            count <= count - 2'd1;
         else if (wr && !pop)
            count <= count + 2'd1;
      end
   end

   // buffer contents; validity is carried by count alone
   always_ff @(posedge CLK) begin
      if (JUMP) begin
         if (state == REQ) old_addr <= fpc;
      end else if (!skip_pop) begin
         case ({pop, wr})
            2'b10: begin
               word0 <= word1;
               addr0 <= addr1;
            end
            2'b01: begin
               if (count == 2'd0) begin
                  word0 <= MEM_DIN;
                  addr0 <= fpc;
               end else begin
                  word1 <= MEM_DIN;
                  addr1 <= fpc;
               end
            end
            2'b11: begin
               if (count == 2'd1) begin
                  word0 <= MEM_DIN;
                  addr0 <= fpc;
               end else begin
                  word0 <= word1;
                  addr0 <= addr1;
                  word1 <= MEM_DIN;
                  addr1 <= fpc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Bench for instruction_fetch: memory responder returning word = address with
// a configurable number of wait cycles, and a scoreboard of expected
// {address, word} pairs consumed whenever the decode side pops.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [15:0] MEM_ADDR;
   logic        MEM_RD;
   logic        MEM_ACK = 1'b0;
   logic [15:0] MEM_DIN = 16'h0000;
   logic [15:0] INSTR;
   logic        INSTR_VALID;
   logic        INSTR_READY = 1'b0;
   logic [15:0] PC_OUT;
   logic        JUMP = 1'b0;
   logic [15:0] JUMP_ADDR = 16'h0000;
   logic        SKIP = 1'b0;
   logic        HALT = 1'b0;

   int tests = 0;
   int fails = 0;
   int wait_cfg = 0;
   int wait_left = 0;
   bit sb_on = 1'b0;
   logic [31:0] exp_q[$];

   instruction_fetch #(.RESET_VECTOR(16'h0000)) dut (
      .CLK(CLK), .RESET(RESET), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
      .MEM_ACK(MEM_ACK), .MEM_DIN(MEM_DIN), .INSTR(INSTR),
      .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .PC_OUT(PC_OUT),
      .JUMP(JUMP), .JUMP_ADDR(JUMP_ADDR), .SKIP(SKIP), .HALT(HALT)
   );

   always #5 CLK = ~CLK;

   // memory: word = address, acknowledges after wait_cfg wait cycles
   always @(negedge CLK) begin
      if (RESET || MEM_ACK) wait_left = wait_cfg;
      if (MEM_RD) begin
         if (wait_left == 0) MEM_ACK = 1'b1;
         else begin
            MEM_ACK = 1'b0;
            wait_left = wait_left - 1;
         end
      end else begin
         MEM_ACK = 1'b0;
      end
      MEM_DIN = MEM_ADDR;
   end

   // scoreboard: every pop must match the next expected {pc, word}
   always @(negedge CLK) begin
      logic [31:0] e;
      if (sb_on && INSTR_VALID && INSTR_READY) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: INSTR=%h PC_OUT=%h popped, none expected", INSTR, PC_OUT);
         end else begin
            e = exp_q.pop_front();
            if (INSTR !== e[15:0] || PC_OUT !== e[31:16]) begin
               fails++;
               $display("FAIL sb_instr: INSTR=%h PC_OUT=%h expected INSTR=%h PC_OUT=%h",
                        INSTR, PC_OUT, e[15:0], e[31:16]);
            end
         end
      end
   end

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic push_exp(input logic [15:0] a);
      exp_q.push_back({a, a});
   endtask

   task automatic do_reset(input int waits);
      RESET = 1'b1;
      INSTR_READY = 1'b0; SKIP = 1'b0; JUMP = 1'b0; HALT = 1'b0;
      wait_cfg = waits;
      sb_on = 1'b0;
      exp_q.delete();
      step();
      step();
      RESET = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: %0d expected words still pending, required 0", name, exp_q.size());
      end
      INSTR_READY = 1'b0;
      sb_on = 1'b0;
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      wait_cfg = 0;
      step();
      step();
      tests++;
      if (MEM_RD !== 1'b0 || INSTR_VALID !== 1'b0 || INSTR !== 16'h0000 ||
          PC_OUT !== 16'h0000 || MEM_ADDR !== 16'h0000) begin
         fails++;
         $display("FAIL reset_state: rd=%b vld=%b instr=%h pc=%h addr=%h, required 0 0 0000 0000 0000",
                  MEM_RD, INSTR_VALID, INSTR, PC_OUT, MEM_ADDR);
      end
      RESET = 1'b0;
      step();
      tests++;
      if (MEM_RD !== 1'b1 || INSTR_VALID !== 1'b0) begin
         fails++;
         $display("FAIL reset_first_req: rd=%b vld=%b, required 1 0", MEM_RD, INSTR_VALID);
      end
      step();
      tests++;
      if (INSTR_VALID !== 1'b1 || INSTR !== 16'h0000 || PC_OUT !== 16'h0000) begin
         fails++;
         $display("FAIL reset_first_word: vld=%b instr=%h pc=%h, required 1 0000 0000",
                  INSTR_VALID, INSTR, PC_OUT);
      end
   endtask

   task automatic test_stream;
      int vcnt = 0;
      do_reset(0);
      INSTR_READY = 1'b1;
      sb_on = 1'b1;
      for (int i = 0; i < 10; i++) push_exp(16'(i));
      for (int i = 0; i < 4; i++) step();
      for (int i = 0; i < 12; i++) begin
         if (INSTR_VALID) vcnt++;
         step();
      end
      tests++;
      if (vcnt != 6) begin
         fails++;
         $display("FAIL stream_rate: %0d valid cycles in 12, required 6", vcnt);
      end
      wait_empty("stream");
   endtask

   task automatic test_buffer_full;
      bit rd_seen = 1'b0;
      int n = 0;
      do_reset(0);
      for (int i = 0; i < 8; i++) step();
      for (int i = 0; i < 4; i++) begin
         if (MEM_RD) rd_seen = 1'b1;
         step();
      end
      tests++;
      if (rd_seen || INSTR_VALID !== 1'b1 || INSTR !== 16'h0000) begin
         fails++;
         $display("FAIL full_hold: rd_seen=%b vld=%b instr=%h, required 0 1 0000",
                  rd_seen, INSTR_VALID, INSTR);
      end
      sb_on = 1'b1;
      push_exp(16'h0000);
      push_exp(16'h0001);
      INSTR_READY = 1'b1;
      step();
      while (!MEM_RD && n < 10) begin
         step();
         n++;
      end
      tests++;
      if (MEM_RD !== 1'b1 || MEM_ADDR !== 16'h0002) begin
         fails++;
         $display("FAIL full_resume: rd=%b addr=%h, required 1 0002", MEM_RD, MEM_ADDR);
      end
      wait_empty("full");
   endtask

   task automatic test_jump;
      int n = 0;
      do_reset(3);
      step();
      step();
      JUMP = 1'b1;
      JUMP_ADDR = 16'h0100;
      step();
      JUMP = 1'b0;
      tests++;
      if (MEM_RD !== 1'b1 || MEM_ADDR !== 16'h0000) begin
         fails++;
         $display("FAIL jump_hold_old: rd=%b addr=%h, required 1 0000", MEM_RD, MEM_ADDR);
      end
      while (MEM_RD && n < 20) begin
         step();
         n++;
      end
      n = 0;
      while (!MEM_RD && n < 20) begin
         step();
         n++;
      end
      tests++;
      if (MEM_RD !== 1'b1 || MEM_ADDR !== 16'h0100) begin
         fails++;
         $display("FAIL jump_target: rd=%b addr=%h, required 1 0100", MEM_RD, MEM_ADDR);
      end
      sb_on = 1'b1;
      push_exp(16'h0100);
      push_exp(16'h0101);
      INSTR_READY = 1'b1;
      wait_empty("jump");
   endtask

   task automatic test_skip;
      int n = 0;
      // two entries buffered: heads 5,6
      do_reset(0);
      JUMP = 1'b1;
      JUMP_ADDR = 16'h0005;
      step();
      JUMP = 1'b0;
      for (int i = 0; i < 8; i++) step();
      tests++;
      if (INSTR !== 16'h0005) begin
         fails++;
         $display("FAIL skip2_head: instr=%h, required 0005", INSTR);
      end
      sb_on = 1'b1;
      push_exp(16'h0005);
      push_exp(16'h0007);
      push_exp(16'h0008);
      INSTR_READY = 1'b1;
      SKIP = 1'b1;
      step();
      SKIP = 1'b0;
      tests++;
      if (INSTR_VALID !== 1'b0) begin
         fails++;
         $display("FAIL skip2_clear: vld=%b, required 0", INSTR_VALID);
      end
      wait_empty("skip2");
      // single entry buffered: head 5
      do_reset(0);
      JUMP = 1'b1;
      JUMP_ADDR = 16'h0005;
      step();
      JUMP = 1'b0;
      while (!INSTR_VALID && n < 10) begin
         step();
         n++;
      end
      sb_on = 1'b1;
      push_exp(16'h0005);
      push_exp(16'h0007);
      push_exp(16'h0008);
      INSTR_READY = 1'b1;
      SKIP = 1'b1;
      step();
      SKIP = 1'b0;
      wait_empty("skip1");
   endtask

   task automatic test_wrap;
      do_reset(0);
      INSTR_READY = 1'b1;
      sb_on = 1'b1;
      push_exp(16'hFFFE);
      push_exp(16'hFFFF);
      push_exp(16'h0000);
      push_exp(16'h0001);
      JUMP = 1'b1;
      JUMP_ADDR = 16'hFFFE;
      step();
      JUMP = 1'b0;
      wait_empty("wrap");
   endtask

   task automatic test_halt_reset;
      bit rd_seen = 1'b0;
      int n = 0;
      do_reset(2);
      INSTR_READY = 1'b1;
      sb_on = 1'b1;
      push_exp(16'h0000);
      step();
      HALT = 1'b1;
      for (int i = 0; i < 4; i++) step();
      for (int i = 0; i < 8; i++) begin
         if (MEM_RD) rd_seen = 1'b1;
         step();
      end
      tests++;
      if (rd_seen) begin
         fails++;
         $display("FAIL halt_block: MEM_RD seen=%b while halted, required 0", rd_seen);
      end
      wait_empty("halt");
      HALT = 1'b0;
      INSTR_READY = 1'b1;
      sb_on = 1'b1;
      push_exp(16'h0001);
      push_exp(16'h0002);
      wait_empty("halt_resume");
      while (!MEM_RD && n < 10) begin
         step();
         n++;
      end
      RESET = 1'b1;
      step();
      tests++;
      if (MEM_RD !== 1'b0 || INSTR_VALID !== 1'b0 || MEM_ADDR !== 16'h0000) begin
         fails++;
         $display("FAIL reset_midreq: rd=%b vld=%b addr=%h, required 0 0 0000",
                  MEM_RD, INSTR_VALID, MEM_ADDR);
      end
      step();
      RESET = 1'b0;
      tests++;
      if (INSTR_VALID !== 1'b0) begin
         fails++;
         $display("FAIL reset_nowrite: vld=%b, required 0", INSTR_VALID);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_buffer_full();
      test_jump();
      test_skip();
      test_wrap();
      test_halt_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_VECTOR, 16'h0000, fetch address loaded on reset.
REQ-002 CLK  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 MEM_ADDR  output  16  fetch address, equal to FPC (fetch program counter).
REQ-005 MEM_RD  output  1  read request; high in states REQ and DISCARD only.
REQ-006 MEM_ACK  input  1  memory has valid data on MEM_DIN this cycle; ignored while MEM_RD=0.
REQ-007 MEM_DIN  input  16  instruction word from memory.
REQ-008 INSTR  output  16  instruction word at buffer head; 16'h0000 when empty.
REQ-009 INSTR_VALID  output  1  buffer non-empty.
REQ-010 INSTR_READY  input  1  decode stage accepts the head this cycle.
REQ-011 PC_OUT  output  16  address of the head instruction; 16'h0000 when empty.
REQ-012 JUMP  input  1  redirect fetch to JUMP_ADDR, flushing everything in flight.
REQ-013 JUMP_ADDR  input  16  jump target.
REQ-014 SKIP  input  1  drop the instruction after the one popped this cycle.
REQ-015 HALT  input  1  stop issuing new memory requests while high.

Function
REQ-016 Buffer SHALL be a 2-entry FIFO of {word, address}; pop = INSTR_VALID & INSTR_READY; count range 0..2.
REQ-017 FSM states SHALL be IDLE, REQ, DISCARD.
REQ-018 IDLE->REQ when count<2, HALT=0, JUMP=0; otherwise stay in IDLE.
REQ-019 In REQ, MEM_ADDR and MEM_RD SHALL stay stable until MEM_ACK; on MEM_ACK write {MEM_DIN, FPC} into the buffer, FPC<=FPC+1 with wrap 16'hFFFF->16'h0000, then go to IDLE.
REQ-020 At most one request outstanding; minimum one IDLE cycle between requests (peak rate 1 word per 2 cycles).
REQ-021 JUMP SHALL take priority over ACK, pop and SKIP: buffer cleared, pending-skip cleared, FPC<=JUMP_ADDR; REQ->DISCARD if MEM_ACK=0 that cycle, otherwise ->IDLE with the word discarded.
REQ-022 DISCARD SHALL hold MEM_RD=1 with the old address until MEM_ACK, drop the data, then go to IDLE; a further JUMP in DISCARD only reloads FPC.
REQ-023 SKIP SHALL be honoured only in a pop cycle; SKIP without pop is ignored.
REQ-024 SKIP with pop and count=2: both entries removed the same cycle (count->0).
REQ-025 SKIP with pop and count=1: pending-skip set; the next word returned by memory is not written, FPC still increments, pending-skip clears.
REQ-026 Simultaneous ACK-write and pop SHALL keep count unchanged, preserving order.
REQ-027 HALT SHALL block only new requests; an outstanding request completes normally and the buffer continues to drain.
REQ-028 The buffer SHALL never overflow: a request is issued only when count<2 and count cannot increase while a request is outstanding.

Reset
REQ-029 With RESET high at a clock edge: FSM->IDLE, FPC=RESET_VECTOR, count=0, pending-skip=0, MEM_RD=0, INSTR=0, INSTR_VALID=0, PC_OUT=0.
REQ-030 Reset mid-request SHALL drop MEM_RD on the next edge with no buffer write.
REQ-031 First edge with RESET low: IDLE->REQ; with zero-wait memory (MEM_ACK tied high) INSTR_VALID rises after the second edge.

Verification
REQ-032 Reset release, zero-wait memory returning word=address, INSTR_READY=1 -> INSTR 0,1,2,... on alternate cycles, PC_OUT=INSTR.
REQ-033 INSTR_READY=0 -> exactly two words buffered, MEM_RD stays 0; READY=1 -> words 0,1 delivered in order, fetch of 2 resumes.
REQ-034 JUMP to 16'h0100 while REQ waiting 3 cycles on ACK -> old address held until ACK, its data dropped, next MEM_ADDR=16'h0100, next INSTR=word@0x0100.
REQ-035 Pop with SKIP at count=2 (heads 5,6) -> next INSTR is 7; at count=1 (head 5) -> word 6 not delivered, next INSTR is 7.
REQ-036 FPC=16'hFFFF, no jump -> after 16'hFFFF next MEM_ADDR=16'h0000.
REQ-037 HALT high during outstanding request -> that word delivered, no further MEM_RD until HALT low; RESET mid-request -> MEM_RD low next cycle, INSTR_VALID=0, MEM_ADDR=RESET_VECTOR.
